// File: rtl/prog_tick_gen_pkg.sv
// prog_tick_gen_pkg: shared types and default constants for prog_tick_gen.
//   state_e : top-level run/idle state.
//   mode_e  : per-channel output mode (square wave or one-cycle pulse).
//   DEFAULT_* : default parameter values (50 MHz clock -> 1 kHz base tick,
//               16-bit divide values, 1000 base ticks per channel event).
package prog_tick_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    localparam int DEFAULT_PRE_DIV = 50000;
    localparam int DEFAULT_DIV_W   = 16;
    localparam int DEFAULT_DEF_DIV = 1000;

endpackage

// File: rtl/prog_tick_gen_tick_channel.sv
// tick_channel: one programmable output channel of prog_tick_gen.
// Divides the shared base tick by a runtime divide value and drives either a
// square wave (toggle per event) or a one-cycle pulse (the cycle after the event).
//   clk, reset     : system clock, asynchronous active-high reset
//   base_tick_i    : one-cycle base tick from the shared prescaler
//   clear_i        : stop request; clears cnt and output, keeps div/mode
//   cfg_we_i       : write strobe already decoded for this channel
//   cfg_div_i      : new divide value (0 disables the channel)
//   cfg_mode_i     : new mode, 0 = square, 1 = pulse
//   ch_out_o       : channel output (registered)
module tick_channel
    import prog_tick_gen_pkg::*;
#(
    parameter int DIV_W   = DEFAULT_DIV_W,
    parameter int DEF_DIV = DEFAULT_DEF_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             base_tick_i,
    input  logic             clear_i,
    input  logic             cfg_we_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic             cfg_mode_i,
    output logic             ch_out_o
);

    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    mode_e            mode_q, mode_d;
    logic             out_q, out_d;
    logic             event_hit;

    always_comb begin
        div_d     = div_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        event_hit = 1'b0;
        if (cfg_we_i) begin
            // A write takes priority over a coinciding event: the event is dropped.
            div_d  = cfg_div_i;
            mode_d = mode_e'(cfg_mode_i);
            cnt_d  = '0;
            // Only a square->square write to an enabled divide keeps the current level.
            if ((mode_d != mode_q) || (mode_d == MODE_PULSE) || (cfg_div_i == '0)) begin
                out_d = 1'b0;
            end
        end else if (div_q == '0) begin
            cnt_d = '0;
            out_d = 1'b0;
        end else begin
            if (base_tick_i) begin
                if (cnt_q == div_q - DIV_ONE) begin
                    cnt_d     = '0;
                    event_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + DIV_ONE;
                end
            end
            if (mode_q == MODE_PULSE) begin
                out_d = event_hit;
            end else begin
                out_d = out_q ^ event_hit;
            end
        end
        // Stop realigns every channel; configuration itself survives.
        if (clear_i) begin
            cnt_d = '0;
            out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= DIV_RESET;
            mode_q <= MODE_SQUARE;
            cnt_q  <= '0;
            out_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    assign ch_out_o = out_q;

endmodule

// File: rtl/prog_tick_gen.sv
// prog_tick_gen: multi-channel programmable timebase generator.
// A shared prescaler produces a base tick every PRE_DIV clocks while running;
// N_CH tick_channel instances divide it by per-channel runtime values.
// Optional macro PROG_TICK_GEN_SYNC_IN_EN: start/stop go through a 2-flop
// synchronizer plus rising-edge detect (level inputs, 3-cycle start latency);
// otherwise they are synchronous single-cycle pulses (1-cycle latency).
//   clk, reset : system clock, asynchronous active-high reset
//   start/stop : IDLE->RUN / RUN->IDLE requests (stop wins when both)
//   cfg_we, cfg_ch, cfg_div, cfg_mode : channel configuration write
//   base_tick  : one-cycle pulse per prescaler wrap
//   ch_out     : per-channel outputs
//   running    : high while in RUN
module prog_tick_gen
    import prog_tick_gen_pkg::*;
#(
    parameter int PRE_DIV = DEFAULT_PRE_DIV,
    parameter int N_CH    = 4,
    parameter int DIV_W   = DEFAULT_DIV_W,
    parameter int DEF_DIV = DEFAULT_DEF_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_mode,
    output logic             base_tick,
    output logic [N_CH-1:0]  ch_out,
    output logic             running
);

    localparam int              PRE_W   = $clog2(PRE_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    logic start_p, stop_p;

`ifdef PROG_TICK_GEN_SYNC_IN_EN
    // Bits [1:0] are the synchronizer flops, bit [2] is the previous synchronized
    // level used for rising-edge detection.
    logic [2:0] start_sync_q, stop_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_sync_q <= '0;
            stop_sync_q  <= '0;
        end else begin
            start_sync_q <= {start_sync_q[1:0], start};
            stop_sync_q  <= {stop_sync_q[1:0], stop};
        end
    end

    assign start_p = start_sync_q[1] & ~start_sync_q[2];
    assign stop_p  = stop_sync_q[1] & ~stop_sync_q[2];
`else
    assign start_p = start;
    assign stop_p  = stop;
`endif

    state_e           state_q, state_d;
    logic             stop_acc;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             base_tick_q, base_tick_d;

    // FSM next state; stop_acc marks an accepted stop (only meaningful in RUN).
    always_comb begin
        state_d  = state_q;
        stop_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_p && !stop_p) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop_p) begin
                    state_d  = IDLE;
                    stop_acc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Prescaler; base_tick is registered so it appears PRE_DIV cycles after running rises.
    always_comb begin
        pre_d       = pre_q;
        base_tick_d = 1'b0;
        if (stop_acc) begin
            pre_d = '0;
        end else if (state_q == RUN) begin
            if (pre_q == PRE_MAX) begin
                pre_d       = '0;
                base_tick_d = 1'b1;
            end else begin
                pre_d = pre_q + PRE_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pre_q       <= '0;
            base_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            base_tick_q <= base_tick_d;
        end
    end

    assign running   = (state_q == RUN);
    assign base_tick = base_tick_q;

    // Writes to cfg_ch >= N_CH match no instance and are dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tick_channel #(
            .DIV_W  (DIV_W),
            .DEF_DIV(DEF_DIV)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .base_tick_i(base_tick_q),
            .clear_i    (stop_acc),
            .cfg_we_i   (cfg_we && (cfg_ch == 3'(i))),
            .cfg_div_i  (cfg_div),
            .cfg_mode_i (cfg_mode),
            .ch_out_o   (ch_out[i])
        );
    end

endmodule

// File: tb/tb_prog_tick_gen.sv
// tb_prog_tick_gen: randomized + directed bench for prog_tick_gen
// (PRE_DIV=4, N_CH=2, DEF_DIV=3). A reference model based on "base ticks since
// phase origin" predicts {running, base_tick, ch_out} every cycle; expected
// vectors are queued at the posedge and compared by a monitor on the negedge.
module tb_prog_tick_gen;

    localparam int PRE_DIV = 4;
    localparam int N_CH    = 2;
    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 3;
    localparam int OW      = 2 + N_CH;

    logic             clk = 1'b0;
    logic             reset;
    logic             start, stop, cfg_we, cfg_mode;
    logic [2:0]       cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             base_tick, running;
    logic [N_CH-1:0]  ch_out;

    always #5 clk = ~clk;

    prog_tick_gen #(
        .PRE_DIV(PRE_DIV),
        .N_CH   (N_CH),
        .DIV_W  (DIV_W),
        .DEF_DIV(DEF_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .base_tick(base_tick),
        .ch_out   (ch_out),
        .running  (running)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    logic [OW-1:0] exp_q[$];

    // Reference model state
    bit m_run;           // in RUN
    int m_r;             // clock edges spent in RUN since start
    bit m_bt;            // base tick visible this cycle
    int m_n[N_CH];       // base ticks seen since channel phase origin
    int m_div[N_CH];
    bit m_mode[N_CH];
    bit m_out[N_CH];
    bit m_st_s1, m_st_s2, m_st_s3, m_sp_s1, m_sp_s2, m_sp_s3;

    function automatic logic [OW-1:0] model_vec();
        logic [OW-1:0] v;
        v = '0;
        v[OW-1] = m_run;
        v[OW-2] = m_bt;
        for (int c = 0; c < N_CH; c++) v[c] = m_out[c];
        return v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_r = 0; m_bt = 0;
        m_st_s1 = 0; m_st_s2 = 0; m_st_s3 = 0;
        m_sp_s1 = 0; m_sp_s2 = 0; m_sp_s3 = 0;
        for (int c = 0; c < N_CH; c++) begin
            m_n[c] = 0; m_div[c] = DEF_DIV; m_mode[c] = 0; m_out[c] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit st, sp, stop_acc, start_acc, keep;
`ifdef PROG_TICK_GEN_SYNC_IN_EN
        st = m_st_s2 && !m_st_s3;
        sp = m_sp_s2 && !m_sp_s3;
        m_st_s3 = m_st_s2; m_st_s2 = m_st_s1; m_st_s1 = start;
        m_sp_s3 = m_sp_s2; m_sp_s2 = m_sp_s1; m_sp_s1 = stop;
`else
        st = start;
        sp = stop;
`endif
        stop_acc  = m_run && sp;
        start_acc = !m_run && st && !sp;
        for (int c = 0; c < N_CH; c++) begin
            if (cfg_we && (int'(cfg_ch) == c)) begin
                keep = (m_mode[c] == cfg_mode) && !cfg_mode && (cfg_div != 0);
                m_div[c]  = int'(cfg_div);
                m_mode[c] = cfg_mode;
                m_n[c]    = 0;
                if (!keep) m_out[c] = 0;
            end else if (m_div[c] == 0) begin
                m_n[c] = 0; m_out[c] = 0;
            end else if (m_bt) begin
                m_n[c]++;
                if (m_n[c] % m_div[c] == 0) m_out[c] = m_mode[c] ? 1'b1 : !m_out[c];
                else if (m_mode[c]) m_out[c] = 0;
            end else if (m_mode[c]) begin
                m_out[c] = 0;
            end
            if (stop_acc) begin
                m_n[c] = 0; m_out[c] = 0;
            end
        end
        if (stop_acc) begin
            m_run = 0; m_r = 0; m_bt = 0;
        end else if (start_acc) begin
            m_run = 1; m_r = 0; m_bt = 0;
        end else if (m_run) begin
            m_r++;
            m_bt = (m_r % PRE_DIV) == 0;
        end else begin
            m_bt = 0;
        end
    endtask

    // One clock: update model at the edge, queue its prediction, return at negedge.
    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        exp_q.push_back(model_vec());
        @(negedge clk);
        cycle++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic write_cfg(input int ch, input int dv, input bit md);
        cfg_we = 1; cfg_ch = 3'(ch); cfg_div = DIV_W'(dv); cfg_mode = md;
        tick();
        cfg_we = 0;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents {running, base_tick, ch_out}.
    initial begin
        logic [OW-1:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {running, base_tick, ch_out};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got run/bt/ch=%b expected %b", cycle, act_v, exp_v);
                end
            end
        end
    end

    initial begin
        reset = 1; start = 0; stop = 0; cfg_we = 0; cfg_ch = '0; cfg_div = '0; cfg_mode = 0;
        model_reset();
        run_cycles(3);
        reset = 0;
        run_cycles(2);

        // Start, default divide 3 square on both channels.
        pulse_start();
        run_cycles(60);

        // Channel 1 to pulse mode, divide 2.
        write_cfg(1, 2, 1'b1);
        run_cycles(40);

        // Channel 0 disabled.
        write_cfg(0, 0, 1'b0);
        run_cycles(60);
        write_cfg(0, 3, 1'b0);
        run_cycles(30);

        // Simultaneous start and stop while running.
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        run_cycles(6);
        pulse_start();
        run_cycles(40);

        // Ignored write to a channel that does not exist, then a reprogram.
        write_cfg(5, 1, 1'b1);
        write_cfg(0, 5, 1'b0);
        run_cycles(27);

        // Asynchronous reset mid-period.
        #2 reset = 1;
        #1;
        check_bit("async_reset_running", running, 1'b0);
        check_bit("async_reset_base_tick", base_tick, 1'b0);
        check_bit("async_reset_ch_out0", ch_out[0], 1'b0);
        check_bit("async_reset_ch_out1", ch_out[1], 1'b0);
        model_reset();
        run_cycles(2);
        reset = 0;
        run_cycles(2);
        pulse_start();
        run_cycles(40);

        // Level start held high for 10 cycles: exactly one start accepted.
        stop = 1; tick(); stop = 0;
        run_cycles(4);
        start = 1; run_cycles(10); start = 0;
        run_cycles(30);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            start    = ($urandom_range(0, 39) == 0);
            stop     = ($urandom_range(0, 79) == 0);
            cfg_we   = ($urandom_range(0, 24) == 0);
            cfg_ch   = 3'($urandom_range(0, 3));
            cfg_div  = DIV_W'($urandom_range(0, 4));
            cfg_mode = 1'($urandom_range(0, 1));
            tick();
        end
        start = 0; stop = 0; cfg_we = 0;
        run_cycles(4);

        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
